// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer pixel writer.
// Optional double buffering is selected with FB_DOUBLE_BUFFER_EN.
package fb_pkg;

   localparam int unsigned H_RES_DEFAULT = 320;
   localparam int unsigned V_RES_DEFAULT = 180;
   localparam int unsigned FB_PIXELS     = H_RES_DEFAULT * V_RES_DEFAULT;

`ifdef FB_DOUBLE_BUFFER_EN
   localparam int unsigned BANK_BITS = 1;
`else
   localparam int unsigned BANK_BITS = 0;
`endif

   typedef struct packed {
      logic [7:0] ch2;
      logic [7:0] ch1;
      logic [7:0] ch0;
   } pixel_t;

   typedef enum logic [0:0] {
      WRITE,
      WAIT_SWAP
   } state_t;

   // Counter width that stays at least one bit for degenerate sizes.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position tracker: x/y position plus a running linear pixel index.
// The linear index is kept as its own counter so no multiplier is needed.
module raster_counter
   import fb_pkg::*;
#(
   parameter int unsigned H_RES = H_RES_DEFAULT,
   parameter int unsigned V_RES = V_RES_DEFAULT,
   localparam int unsigned ADDR_W = clog2_min1(H_RES * V_RES),
   localparam int unsigned X_W    = clog2_min1(H_RES),
   localparam int unsigned Y_W    = clog2_min1(V_RES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   output logic [X_W-1:0]    x,
   output logic [Y_W-1:0]    y,
   output logic [ADDR_W-1:0] pix,
   output logic              last
);

   localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
   localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

   logic [X_W-1:0]    x_q, x_d;
   logic [Y_W-1:0]    y_q, y_d;
   logic [ADDR_W-1:0] pix_q, pix_d;

   assign last = (x_q == X_MAX) && (y_q == Y_MAX);
   assign x    = x_q;
   assign y    = y_q;
   assign pix  = pix_q;

   // Advance one pixel per inc, wrapping line and frame.
   always_comb begin
      x_d   = x_q;
      y_d   = y_q;
      pix_d = pix_q;
      if (inc) begin
         if (last) begin
            x_d   = '0;
            y_d   = '0;
            pix_d = '0;
         end else begin
            pix_d = pix_q + ADDR_W'(1);
            if (x_q == X_MAX) begin
               x_d = '0;
               y_d = y_q + Y_W'(1);
            end else begin
               x_d = x_q + X_W'(1);
            end
         end
      end
   end

   // Counter state.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q   <= '0;
         y_q   <= '0;
         pix_q <= '0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         pix_q <= pix_d;
      end
   end

endmodule

// File: rtl/fb_pixel_writer.sv
// Pixel stream to frame-buffer BRAM writer with raster tracking and end-of-frame pulse.
// Define FB_DOUBLE_BUFFER_EN for two banks swapped on display vsync.
module fb_pixel_writer
   import fb_pkg::*;
#(
   parameter int unsigned H_RES = H_RES_DEFAULT,
   parameter int unsigned V_RES = V_RES_DEFAULT,
   localparam int unsigned ADDR_W = clog2_min1(H_RES * V_RES),
   localparam int unsigned FB_AW  = ADDR_W + BANK_BITS
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic [23:0]      s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   output logic [FB_AW-1:0] fb_addr,
   output logic [23:0]      fb_wdata,
   output logic             fb_we,
   output logic             frame_done,
   input  logic             display_vsync,
   output logic             fb_front_bank
);

   localparam int unsigned X_W = clog2_min1(H_RES);
   localparam int unsigned Y_W = clog2_min1(V_RES);

   state_t            state_q, state_d;
   logic              front_q, front_d;
   logic              accept;
   logic              last;
   logic [X_W-1:0]    x;
   logic [Y_W-1:0]    y;
   logic [ADDR_W-1:0] pix;
   logic [FB_AW-1:0]  addr_d;
   pixel_t            pix_in;

   // Position is tracked inside the counter; x/y are not needed for the address.
   logic unused_pos;
   assign unused_pos = ^{x, y};

   assign pix_in = pixel_t'(s_axis_tdata);
   assign accept = s_axis_tvalid && s_axis_tready;

   raster_counter #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) u_raster_counter (
      .clk  (aclk),
      .rst  (areset),
      .inc  (accept),
      .x    (x),
      .y    (y),
      .pix  (pix),
      .last (last)
   );

   // FSM state register.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= WRITE;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef FB_DOUBLE_BUFFER_EN
   // Next state: park after the last pixel until the display has moved to the new frame.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WRITE:     if (accept && last) state_d = WAIT_SWAP;
         WAIT_SWAP: if (display_vsync) state_d = WRITE;
         default:   state_d = WRITE;
      endcase
   end

   // FSM outputs: ready only while writing; the front bank flips as WAIT_SWAP exits.
   always_comb begin
      s_axis_tready = (state_q == WRITE) && !areset;
      front_d       = front_q;
      if ((state_q == WAIT_SWAP) && display_vsync) begin
         front_d = !front_q;
      end
      addr_d = {!front_q, pix};
   end
`else
   // Single bank: the block stays in WRITE across frames.
   always_comb begin
      state_d = WRITE;
   end

   // FSM outputs: single bank, front bank fixed at 0.
   always_comb begin
      s_axis_tready = (state_q == WRITE) && !areset;
      front_d       = 1'b0;
      addr_d        = pix;
   end

   logic unused_vsync;
   assign unused_vsync = display_vsync ^ front_q;
`endif

   // Registered BRAM write port, end-of-frame pulse and bank select.
   always_ff @(posedge aclk) begin
      if (areset) begin
         fb_addr    <= '0;
         fb_wdata   <= '0;
         fb_we      <= 1'b0;
         frame_done <= 1'b0;
         front_q    <= 1'b0;
      end else begin
         fb_we      <= accept;
         frame_done <= accept && last;
         front_q    <= front_d;
         if (accept) begin
            fb_addr  <= addr_d;
            fb_wdata <= pix_in;
         end
      end
   end

   assign fb_front_bank = front_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer at H_RES=4, V_RES=2.
// Covers double-buffer scenarios when FB_DOUBLE_BUFFER_EN is defined.
module tb_fb_pixel_writer;
   import fb_pkg::*;

   localparam int unsigned HR       = 4;
   localparam int unsigned VR       = 2;
   localparam int unsigned NPIX     = HR * VR;
   localparam int unsigned AW       = 3 + BANK_BITS;
   localparam int          BANK_OFS = 8;

   logic          aclk   = 1'b0;
   logic          areset = 1'b1;
   logic [23:0]   tdata  = '0;
   logic          tvalid = 1'b0;
   logic          vsync  = 1'b0;
   logic          tready;
   logic [AW-1:0] fb_addr;
   logic [23:0]   fb_wdata;
   logic          fb_we;
   logic          frame_done;
   logic          fb_front_bank;

   always #5 aclk = ~aclk;

   fb_pixel_writer #(
      .H_RES (HR),
      .V_RES (VR)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tdata  (tdata),
      .s_axis_tvalid (tvalid),
      .s_axis_tready (tready),
      .fb_addr       (fb_addr),
      .fb_wdata      (fb_wdata),
      .fb_we         (fb_we),
      .frame_done    (frame_done),
      .display_vsync (vsync),
      .fb_front_bank (fb_front_bank)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Behavioural model: pixel count modulo frame size, bank parity, waiting flag.
   int          m_cnt   = 0;
   logic        m_wait  = 1'b0;
   logic        m_front = 1'b0;
   logic        m_we    = 1'b0;
   logic        m_done  = 1'b0;
   int          m_addr  = 0;
   logic [23:0] m_data  = '0;

   always @(posedge aclk) begin
      if (areset) begin
         m_cnt   <= 0;
         m_wait  <= 1'b0;
         m_front <= 1'b0;
         m_we    <= 1'b0;
         m_done  <= 1'b0;
         m_addr  <= 0;
         m_data  <= '0;
      end else begin
         m_we   <= tvalid && !m_wait;
         m_done <= 1'b0;
         if (tvalid && !m_wait) begin
            m_addr <= m_cnt + ((BANK_BITS == 1 && !m_front) ? BANK_OFS : 0);
            m_data <= tdata;
            m_cnt  <= (m_cnt + 1) % NPIX;
            if (m_cnt == NPIX - 1) begin
               m_done <= 1'b1;
               if (BANK_BITS == 1) m_wait <= 1'b1;
            end
         end
         if (m_wait && vsync) begin
            m_wait  <= 1'b0;
            m_front <= !m_front;
         end
      end
   end

   // Per-cycle comparison against the model, plus logs for directed checks.
   int          cyc = 0;
   int          not_ready = 0;
   int          wr_addr[$];
   logic [23:0] wr_data[$];
   int          done_cyc[$];
   int          done_addr[$];

   always @(negedge aclk) begin
      cyc++;
      check("tready", tready, (!areset && !m_wait));
      check("fb_we", fb_we, m_we);
      check("fb_addr", fb_addr, m_addr);
      check("fb_wdata", fb_wdata, m_data);
      check("frame_done", frame_done, m_done);
      check("fb_front_bank", fb_front_bank, m_front);
      if (!areset && !tready) not_ready++;
      if (fb_we) begin
         wr_addr.push_back(int'(fb_addr));
         wr_data.push_back(fb_wdata);
      end
      if (frame_done) begin
         done_cyc.push_back(cyc);
         done_addr.push_back(int'(fb_addr));
      end
   end

   task automatic step(input logic v, input logic [23:0] d);
      tvalid = v;
      tdata  = d;
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset();
      tvalid = 1'b0;
      vsync  = 1'b0;
      areset = 1'b1;
      @(posedge aclk);
      #1;
      @(posedge aclk);
      #1;
      areset = 1'b0;
   endtask

   int wb, db, nr, ones;

   initial begin
      // Reset state.
      areset = 1'b1;
      @(posedge aclk);
      #1;
      @(posedge aclk);
      #1;
      check("rst_fb_we", fb_we, 0);
      check("rst_fb_addr", fb_addr, 0);
      check("rst_fb_wdata", fb_wdata, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_front", fb_front_bank, 0);
      check("rst_tready", tready, 0);
      areset = 1'b0;
      #1;
      check("post_rst_tready", tready, 1);

      // 1: eight back-to-back beats make one frame.
      wb = wr_addr.size();
      db = done_cyc.size();
      for (int i = 1; i <= 8; i++) step(1'b1, 24'(i));
      step(1'b0, '0);
      step(1'b0, '0);
      check("t1_writes", wr_addr.size() - wb, 8);
      check("t1_first_data", wr_data[wb], 24'h000001);
      check("t1_last_data", wr_data[wb+7], 24'h000008);
`ifdef FB_DOUBLE_BUFFER_EN
      check("t1_first_addr", wr_addr[wb], 8);
      check("t1_last_addr", wr_addr[wb+7], 15);
      check("t1_done_addr", done_addr[db], 15);
`else
      check("t1_first_addr", wr_addr[wb], 0);
      check("t1_last_addr", wr_addr[wb+7], 7);
      check("t1_done_addr", done_addr[db], 7);
`endif
      check("t1_done_count", done_cyc.size() - db, 1);

      // 2: gaps in tvalid leave counters alone and produce no bubble writes.
      do_reset();
      wb = wr_addr.size();
      step(1'b1, 24'h0000AA);
      step(1'b0, '0);
      step(1'b0, '0);
      step(1'b1, 24'h0000BB);
      step(1'b0, '0);
      step(1'b0, '0);
      check("t2_writes", wr_addr.size() - wb, 2);
      check("t2_addr0", wr_addr[wb] % BANK_OFS, 0);
      check("t2_addr1", wr_addr[wb+1] % BANK_OFS, 1);
      check("t2_data1", wr_data[wb+1], 24'h0000BB);

      // 3: reset mid-frame abandons it and restarts at address 0.
      do_reset();
      db = done_cyc.size();
      for (int i = 0; i < 5; i++) step(1'b1, 24'(16 + i));
      areset = 1'b1;
      step(1'b0, '0);
      areset = 1'b0;
      step(1'b0, '0);
      check("t3_no_done", done_cyc.size() - db, 0);
      wb = wr_addr.size();
      for (int i = 0; i < 8; i++) step(1'b1, 24'(32 + i));
      step(1'b0, '0);
      check("t3_restart_addr", wr_addr[wb] % BANK_OFS, 0);
      check("t3_restart_data", wr_data[wb], 24'd32);
      check("t3_done_count", done_cyc.size() - db, 1);

`ifdef FB_DOUBLE_BUFFER_EN
      // 4: wait for vsync after a full frame, then write the other bank.
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 24'(64 + i));
      wb = wr_addr.size();
      for (int i = 0; i < 10; i++) begin
         check("t4_wait_tready", tready, 0);
         step(1'b1, 24'hFFFFFF);
      end
      check("t4_no_writes_waiting", wr_addr.size() - wb, 1);
      vsync = 1'b1;
      step(1'b0, '0);
      vsync = 1'b0;
      check("t4_tready_after_vsync", tready, 1);
      check("t4_front_after_vsync", fb_front_bank, 1);
      wb = wr_addr.size();
      db = done_cyc.size();
      for (int i = 0; i < 8; i++) step(1'b1, 24'(96 + i));
      step(1'b0, '0);
      ones = 0;
      for (int i = wb; i < wr_addr.size(); i++) if (wr_addr[i] >= BANK_OFS) ones++;
      check("t4_next_writes", wr_addr.size() - wb, 8);
      check("t4_msb_zero", ones, 0);
      check("t4_done_addr", done_addr[db], 7);

      // 5: vsync in WRITE is ignored; vsync on the first waiting cycle swaps at once.
      do_reset();
      step(1'b1, 24'd1);
      vsync = 1'b1;
      step(1'b1, 24'd2);
      vsync = 1'b0;
      step(1'b1, 24'd3);
      check("t5_no_swap_in_write", fb_front_bank, 0);
      for (int i = 4; i <= 8; i++) step(1'b1, 24'(i));
      tvalid = 1'b0;
      check("t5_wait_tready", tready, 0);
      check("t5_done_now", frame_done, 1);
      vsync = 1'b1;
      step(1'b0, '0);
      vsync = 1'b0;
      check("t5_tready_back", tready, 1);
      check("t5_front_swapped", fb_front_bank, 1);
`else
      // 6: two consecutive frames without any ready drop.
      do_reset();
      db = done_cyc.size();
      nr = not_ready;
      for (int i = 0; i < 16; i++) step(1'b1, 24'(128 + i));
      step(1'b0, '0);
      check("t6_done_count", done_cyc.size() - db, 2);
      check("t6_done_spacing", done_cyc[db+1] - done_cyc[db], 8);
      check("t6_no_ready_drop", not_ready - nr, 0);
      check("t6_done_addr", done_addr[db+1], 7);
`endif

      step(1'b0, '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
